// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON engine host interface.
// FSM encoding, register offsets and STATUS bit positions.
package ascon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_RD,
        ST_ACK
    } wb_state_t;

    localparam logic [7:0] OFF_CTRL    = 8'h80;
    localparam logic [7:0] OFF_STATUS  = 8'h84;
    localparam logic [7:0] OFF_DATALEN = 8'h88;
    localparam logic [7:0] OFF_IRQEN   = 8'h8C;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/wb_host_if.sv
// Wishbone classic slave front-end for the ASCON engine: memory window + control regs.
// Optional ASCON_IRQ_EN adds the IRQEN register and a done-level interrupt.
module wb_host_if
    import ascon_pkg::*;
(
    input  logic        clk,
    input  logic        nRST,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] datain_wb,
    input  logic [31:0] mem_dataout,
    output logic        busy,
    output logic [6:0]  datalen,
    input  logic        core_done,
    output logic        irq
);

    wb_state_t   state, state_n;
    logic [31:0] rdata, rdata_n;
    logic [31:0] reg_val;
    logic [7:0]  off;
    logic        req, is_mem, reg_wr;
    logic        start_wr, w1c_wr, mem_blk, cd_eff, err_set;
    logic        done, err, irqen;
    logic        unused_bits;

    assign off     = {wbs_adr_i[7:2], 2'b00};
    assign is_mem  = ~wbs_adr_i[7];
    // Requests are masked during reset so no memory strobe can leak out.
    assign req     = wbs_cyc_i & wbs_stb_i & nRST & (state == ST_IDLE);
    assign reg_wr  = req & wbs_we_i & ~is_mem;
    assign start_wr = reg_wr & (off == OFF_CTRL) & wbs_dat_i[0];
    assign w1c_wr  = reg_wr & (off == OFF_STATUS);
    assign mem_blk = req & is_mem & busy;
    assign cd_eff  = core_done & busy;
    assign err_set = mem_blk | (start_wr & busy);

    assign unused_bits = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

    always_comb begin
        reg_val = 32'h0;
        unique case (1'b1)
            off == OFF_STATUS:  reg_val = {29'h0, err, done, busy};
            off == OFF_DATALEN: reg_val = {25'h0, datalen};
            off == OFF_IRQEN:   reg_val = {31'h0, irqen};
            default:            reg_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
            rdata <= 32'h0;
        end else begin
            state <= state_n;
            rdata <= rdata_n;
        end
    end

    always_comb begin
        state_n   = state;
        rdata_n   = rdata;
        wb_we     = 1'b0;
        wb_addr   = 5'h0;
        datain_wb = 32'h0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    state_n = ST_ACK;
                    rdata_n = 32'h0;
                    if (is_mem && !busy) begin
                        wb_addr = wbs_adr_i[6:2];
                        if (wbs_we_i) begin
                            wb_we     = 1'b1;
                            datain_wb = wbs_dat_i;
                        end else begin
                            state_n = ST_MEM_RD;
                        end
                    end else if (!is_mem && !wbs_we_i) begin
                        rdata_n = reg_val;
                    end
                end
            end
            ST_MEM_RD: begin
                rdata_n = mem_dataout;
                state_n = ST_ACK;
            end
            ST_ACK:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign wbs_ack_o = (state == ST_ACK);
    assign wbs_dat_o = wbs_ack_o ? rdata : 32'h0;

    // Engine completion outranks a concurrent START or done-clear.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            datalen <= 7'h0;
        end else begin
            if (cd_eff) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else if (start_wr && !busy) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (w1c_wr && wbs_dat_i[STAT_DONE]) begin
                done <= 1'b0;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (w1c_wr && wbs_dat_i[STAT_ERR]) begin
                err <= 1'b0;
            end
            if (reg_wr && off == OFF_DATALEN) begin
                datalen <= wbs_dat_i[6:0];
            end
        end
    end

`ifdef ASCON_IRQ_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            irqen <= 1'b0;
        end else if (reg_wr && off == OFF_IRQEN) begin
            irqen <= wbs_dat_i[0];
        end
    end
    assign irq = done & irqen;
`else
    assign irqen = 1'b0;
    assign irq   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_host_if.sv
// Self-checking bench for wb_host_if: vector table plus multi-cycle sequences.
// Build with or without ASCON_IRQ_EN; interrupt expectations follow the macro.
module tb_wb_host_if;

    logic        clk = 1'b0;
    logic        nRST;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] datain_wb;
    logic [31:0] mem_dataout;
    logic        busy;
    logic [6:0]  datalen;
    logic        core_done;
    logic        irq;

    int checks = 0;
    int errors = 0;

`ifdef ASCON_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    wb_host_if dut (
        .clk         (clk),
        .nRST        (nRST),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .datain_wb   (datain_wb),
        .mem_dataout (mem_dataout),
        .busy        (busy),
        .datalen     (datalen),
        .core_done   (core_done),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: data valid the cycle after the address.
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (wb_we) mem[wb_addr] <= datain_wb;
        mem_dataout <= mem[wb_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic cd,
                        output logic [31:0] rd, output int lat,
                        output logic s_we, output logic [4:0] s_addr,
                        output logic [31:0] s_din);
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        core_done = cd;
        #1;
        s_we   = wb_we;
        s_addr = wb_addr;
        s_din  = datain_wb;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            core_done = 1'b0;
            if (wbs_ack_o) begin
                lat = i;
                rd  = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    logic [31:0] rd_v, din_v;
    int          lat_v;
    logic        we_v;
    logic [4:0]  addr_v;

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        xfer(1'b1, adr, dat, 1'b0, rd_v, lat_v, we_v, addr_v, din_v);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr,
                          input logic [31:0] exp, input int exp_lat);
        xfer(1'b0, adr, 32'h0, 1'b0, rd_v, lat_v, we_v, addr_v, din_v);
        chk({name, " data"}, rd_v, exp);
        chk({name, " lat"}, lat_v, exp_lat);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_wbwe;
        logic [4:0]  exp_addr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b1, 32'h14, 32'hDEADBEEF, 32'h0,        1, 1'b1, 5'd5};
        vecs[1]  = '{1'b0, 32'h14, 32'h0,        32'hDEADBEEF, 2, 1'b0, 5'd5};
        vecs[2]  = '{1'b1, 32'h00, 32'h12345678, 32'h0,        1, 1'b1, 5'd0};
        vecs[3]  = '{1'b1, 32'h7C, 32'hCAFEF00D, 32'h0,        1, 1'b1, 5'd31};
        vecs[4]  = '{1'b0, 32'h00, 32'h0,        32'h12345678, 2, 1'b0, 5'd0};
        vecs[5]  = '{1'b0, 32'h7C, 32'h0,        32'hCAFEF00D, 2, 1'b0, 5'd31};
        vecs[6]  = '{1'b1, 32'h88, 32'h28,       32'h0,        1, 1'b0, 5'd0};
        vecs[7]  = '{1'b0, 32'h88, 32'h0,        32'h28,       1, 1'b0, 5'd0};
        vecs[8]  = '{1'b0, 32'h84, 32'h0,        32'h0,        1, 1'b0, 5'd0};
        vecs[9]  = '{1'b1, 32'h90, 32'hFFFFFFFF, 32'h0,        1, 1'b0, 5'd0};
        vecs[10] = '{1'b0, 32'h90, 32'h0,        32'h0,        1, 1'b0, 5'd0};
        vecs[11] = '{1'b1, 32'h8C, 32'h1,        32'h0,        1, 1'b0, 5'd0};
        vecs[12] = '{1'b0, 32'h8C, 32'h0,        {31'h0, IRQ_ON}, 1, 1'b0, 5'd0};

        nRST      = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h14;
        wbs_dat_i = 32'hFFFFFFFF;
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst dat_o", wbs_dat_o, 32'h0);
        chk("rst wb_we", {31'h0, wb_we}, 32'h0);
        chk("rst wb_addr", {27'h0, wb_addr}, 32'h0);
        chk("rst datain", datain_wb, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst datalen", {25'h0, datalen}, 32'h0);
        chk("rst irq", {31'h0, irq}, 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(negedge clk);
        nRST = 1'b1;

        for (int v = 0; v < 13; v++) begin
            xfer(vecs[v].we, vecs[v].adr, vecs[v].dat, 1'b0,
                 rd_v, lat_v, we_v, addr_v, din_v);
            chk($sformatf("vec%0d data", v), rd_v, vecs[v].exp_rd);
            chk($sformatf("vec%0d lat", v), lat_v, vecs[v].exp_lat);
            chk($sformatf("vec%0d wb_we", v), {31'h0, we_v},
                {31'h0, vecs[v].exp_wbwe});
            chk($sformatf("vec%0d wb_addr", v), {27'h0, addr_v},
                {27'h0, vecs[v].exp_addr});
            if (vecs[v].exp_wbwe)
                chk($sformatf("vec%0d datain", v), din_v, vecs[v].dat);
        end

        // Start a run and probe the busy-time behaviour.
        wr(32'h80, 32'h1);
        chk("start busy", {31'h0, busy}, 32'h1);
        chk("datalen 40", {25'h0, datalen}, 32'd40);
        rd_chk("status run", 32'h84, 32'h1, 1);

        xfer(1'b1, 32'h20, 32'h11111111, 1'b0, rd_v, lat_v, we_v, addr_v, din_v);
        chk("blk wr wb_we", {31'h0, we_v}, 32'h0);
        chk("blk wr lat", lat_v, 1);
        rd_chk("status err", 32'h84, 32'h5, 1);
        rd_chk("blk rd", 32'h14, 32'h0, 1);
        wr(32'h84, 32'h4);
        rd_chk("err w1c", 32'h84, 32'h1, 1);

        wr(32'h80, 32'h1);
        rd_chk("restart err", 32'h84, 32'h5, 1);
        wr(32'h84, 32'h4);

        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("done busy", {31'h0, busy}, 32'h0);
        rd_chk("status done", 32'h84, 32'h2, 1);
        chk("irq done", {31'h0, irq}, {31'h0, IRQ_ON});
        rd_chk("blocked wr lost", 32'h20, 32'h0, 2);

        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        rd_chk("idle core_done", 32'h84, 32'h2, 1);

        wr(32'h84, 32'h2);
        chk("irq clr", {31'h0, irq}, 32'h0);
        wr(32'h80, 32'h1);
        rd_chk("rerun", 32'h84, 32'h1, 1);
        xfer(1'b1, 32'h80, 32'h1, 1'b1, rd_v, lat_v, we_v, addr_v, din_v);
        chk("race busy", {31'h0, busy}, 32'h0);
        rd_chk("race status", 32'h84, 32'h6, 1);

        wr(32'h84, 32'h6);
        wr(32'h80, 32'h1);
        xfer(1'b1, 32'h84, 32'h2, 1'b1, rd_v, lat_v, we_v, addr_v, din_v);
        rd_chk("w1c vs done", 32'h84, 32'h2, 1);

        // Master abandons a memory read while it is in flight.
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h14;
        @(negedge clk);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        chk("drop no ack", {31'h0, wbs_ack_o}, 32'h0);
        @(negedge clk);
        chk("drop ack", {31'h0, wbs_ack_o}, 32'h1);
        chk("drop data", wbs_dat_o, 32'hDEADBEEF);
        rd_chk("post drop", 32'h14, 32'hDEADBEEF, 2);
        rd_chk("post drop st", 32'h84, 32'h2, 1);

        wr(32'h80, 32'h1);
        chk("pre rst busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        #2;
        nRST = 1'b0;
        #1;
        chk("async busy", {31'h0, busy}, 32'h0);
        chk("async datalen", {25'h0, datalen}, 32'h0);
        chk("async irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        nRST = 1'b1;
        rd_chk("post rst st", 32'h84, 32'h0, 1);
        rd_chk("post rst irqen", 32'h8C, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_host_if.md
WB_HOST_IF -- requirements
Module: wb_host_if

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 nRST  input  1  asynchronous active-low reset.
REQ-003 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave cycle, strobe and write enable.
REQ-004 wbs_adr_i  input  32  byte address; only bits [7:2] decoded.
REQ-005 wbs_dat_i  input  32  write data.
REQ-006 wbs_ack_o  output  1  single-cycle acknowledge.
REQ-007 wbs_dat_o  output  32  read data, valid while wbs_ack_o=1, else 0.
REQ-008 wb_we  output  1  active-high memory write request toward the memory controller.
REQ-009 wb_addr  output  5  memory word address (wbs_adr_i[6:2]).
REQ-010 datain_wb  output  32  memory write data.
REQ-011 mem_dataout  input  32  synchronous memory read data, valid the cycle after address presentation.
REQ-012 busy  output  1  engine run flag; memory owned by the engine while high.
REQ-013 datalen  output  7  message length in bytes.
REQ-014 core_done  input  1  one-cycle pulse from the engine at run completion.
REQ-015 irq  output  1  level interrupt (see Configuration).

Function
REQ-016 Address map: adr[7]=0 memory window (32 words); 0x80 CTRL (W: bit0 START); 0x84 STATUS (R: bit0 busy, bit1 done, bit2 err; W1C bits1-2); 0x88 DATALEN (RW, bits[6:0]); 0x8C IRQEN (RW bit0); other offsets read 0, writes dropped.
REQ-017 FSM states IDLE, MEM_RD, ACK; request = cyc&stb in IDLE.
REQ-018 IDLE, register or memory write: perform write that cycle, go ACK; ack asserted next cycle (1-cycle latency).
REQ-019 IDLE, memory read while busy=0: drive wb_addr, go MEM_RD; next cycle capture mem_dataout, go ACK (2-cycle latency).
REQ-020 IDLE, register read: capture register value, go ACK.
REQ-021 ACK: wbs_ack_o=1 for exactly one cycle, return to IDLE; new request not accepted in ACK.
REQ-022 wb_we=1 only in IDLE cycle of an accepted memory write with busy=0; wb_addr/datain_wb = 0 when not accessing memory.
REQ-023 Memory-window access while busy=1: no wb_we, read data 0, still acknowledged at 1-cycle latency, STATUS.err set.
REQ-024 START write with busy=0: busy=1 next cycle, done cleared; START while busy=1 ignored and sets err.
REQ-025 core_done while busy=1: busy=0, done=1 next cycle; core_done while busy=0 ignored.
REQ-026 core_done and START write same cycle: done wins; busy=0, done=1, START dropped, err set.
REQ-027 W1C of done concurrent with core_done: done ends at 1.
REQ-028 cyc dropped mid-transaction (MEM_RD): FSM completes to ACK, ack ignored by master; no state corruption.

Reset
REQ-029 nRST low: FSM=IDLE, busy=0, done=0, err=0, datalen=0, irqen=0, wbs_ack_o=0, wbs_dat_o=0, wb_we=0, wb_addr=0, datain_wb=0, irq=0.
REQ-030 Reset mid-run: busy clears immediately; engine sees busy=0 and aborts.

Configuration
REQ-031 Macro ASCON_IRQ_EN defined: irq = done & irqen, IRQEN register implemented.
REQ-032 ASCON_IRQ_EN undefined: irq tied 0, IRQEN reads 0, writes dropped.

Structure
REQ-033 Shared package ascon_pkg holds FSM enum, register offsets (CTRL/STATUS/DATALEN/IRQEN) and STATUS bit indices.
REQ-034 No sub-module; single flat module.

Verification
REQ-035 Write 0xDEADBEEF to 0x14, busy=0 -> wb_we=1, wb_addr=5, datain_wb=0xDEADBEEF one cycle; ack next cycle.
REQ-036 Read 0x14 with mem_dataout=0xDEADBEEF -> ack 2 cycles after stb, wbs_dat_o=0xDEADBEEF.
REQ-037 Write DATALEN=40, CTRL=1 -> datalen=40, busy=1; core_done pulse -> busy=0, STATUS reads 0x2.
REQ-038 Memory write while busy=1 -> wb_we stays 0, ack after 1 cycle, STATUS.err=1; W1C 0x4 clears it.
REQ-039 START and core_done same cycle -> busy=0, done=1, err=1.
REQ-040 ASCON_IRQ_EN defined, IRQEN=1, run completes -> irq=1; W1C done -> irq=0; assert nRST mid-run -> busy=0 asynchronously.
